config_scan_sequencer: RTL

Command-driven sequencer for the pixel-chip configuration shift register.
- Accepts 32-bit commands over a valid/ready stream, typically fed from the AXI4-Lite register block.
- Generates gated ConfigClk, ConfigIn, ConfigLoad, Reset_not and SuperpixSel.
- Captures ConfigOut during shifts and returns the readback words on a valid/ready output stream.
- Sits between the AXI register/FIFO layer and the chip pins.

---
 rtl/config_scan_sequencer_pkg.sv | 30 +++
 rtl/config_scan_sequencer_cfg_clk_phase_gen.sv | 34 +++
 rtl/config_scan_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/config_scan_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and command field positions for the
// configuration scan sequencer.
package cfg_seq_pkg;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_WAIT  = 2'b11;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_W    = 2;
  localparam int unsigned SEL_BIT  = 2;
  localparam int unsigned BCNT_LSB = 4;
  localparam int unsigned BCNT_W   = 4;
  localparam int unsigned PAY_LSB  = 16;
  localparam int unsigned PAY_W    = 16;
  // Remaining half-periods; one bit wider than the payload so 2*0xFFFF fits.
  localparam int unsigned HALF_W   = PAY_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_SHIFT_DONE,
    ST_LOAD,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/config_scan_sequencer_cfg_clk_phase_gen.sv
// ConfigClk half-period timer: counts CLK_DIVIDER-1 down to 0 while enabled,
// flags the last cycle of each half-period and the first enabled cycle.
module cfg_clk_phase_gen #(
  parameter int unsigned CLK_DIVIDER = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_c_o,
  output logic restart_c_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIVIDER);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIVIDER - 1);

  logic [DIV_W-1:0] cnt_q;
  logic             en_q;

  // Reload whenever disabled so every enabled stretch starts a full half-period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RELOAD;
      en_q  <= 1'b0;
    end else begin
      en_q <= en_i;
      if (!en_i || cnt_q == DIV_W'(0)) cnt_q <= RELOAD;
      else                             cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign tick_c_o    = en_i && (cnt_q == DIV_W'(0));
  assign restart_c_o = en_i && !en_q;

endmodule

// File: rtl/config_scan_sequencer.sv
// Command-driven sequencer for the pixel-chip configuration shift register.
// CFG_SEQ_READBACK_EN adds ConfigOut capture and the readback stream.
module config_scan_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int unsigned CLK_DIVIDER  = 100,
  parameter int unsigned RST_PERIODS  = 1,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_DATA_WIDTH-1:0] cmd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [C_DATA_WIDTH-1:0] rd_data,
  output logic                    busy,
  output logic                    SuperpixSel,
  output logic                    ConfigClk,
  output logic                    Reset_not,
  output logic                    ConfigIn,
  output logic                    ConfigLoad,
  input  logic                    ConfigOut
);

  localparam int unsigned RST_HALVES = 2 * RST_PERIODS;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   halves_q, halves_d;
  logic [BCNT_W-1:0]   bit_q, bit_d, nbits_q, nbits_d;
  logic [PAY_W-1:0]    sreg_q, sreg_d;
  logic                sel_q, sel_d, cclk_q, cclk_d, cin_q, cin_d;
  logic                load_q, load_d, rstn_q, rstn_d;
  logic                phase_en_c, tick_c, restart_c;
  logic [OPC_W-1:0]    opcode_c;
  logic                unused_c;

`ifdef CFG_SEQ_READBACK_EN
  logic [PAY_W-1:0]    cap_q, cap_d, rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
`endif

  assign opcode_c   = cmd_data[OPC_LSB +: OPC_W];
  assign phase_en_c = state_q inside {ST_RESET, ST_SHIFT_LO, ST_SHIFT_HI, ST_LOAD, ST_WAIT};

  cfg_clk_phase_gen #(.CLK_DIVIDER(CLK_DIVIDER)) u_phase (
    .clk_i       (S_AXI_ACLK),
    .rst_i       (S_AXI_ARESET),
    .en_i        (phase_en_c),
    .tick_c_o    (tick_c),
    .restart_c_o (restart_c)
  );

  always_comb begin
    state_d  = state_q;
    halves_d = halves_q;
    bit_d    = bit_q;
    nbits_d  = nbits_q;
    sreg_d   = sreg_q;
    sel_d    = sel_q;
`ifdef CFG_SEQ_READBACK_EN
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (opcode_c)
            OP_RESET: begin
              sel_d    = cmd_data[SEL_BIT];
              halves_d = HALF_W'(RST_HALVES);
              state_d  = ST_RESET;
            end
            OP_SHIFT: begin
              sreg_d  = cmd_data[PAY_LSB +: PAY_W];
              nbits_d = cmd_data[BCNT_LSB +: BCNT_W];
              bit_d   = '0;
`ifdef CFG_SEQ_READBACK_EN
              cap_d   = '0;
`endif
              state_d = ST_SHIFT_LO;
            end
            OP_LOAD: begin
              halves_d = HALF_W'(2);
              state_d  = ST_LOAD;
            end
            OP_WAIT: begin
              halves_d = {cmd_data[PAY_LSB +: PAY_W], 1'b0};
              state_d  = ST_WAIT;
            end
          endcase
        end
      end
      // Timed states share one half-period countdown; zero means WAIT 0.
      ST_RESET, ST_LOAD, ST_WAIT: begin
        if (halves_q == HALF_W'(0)) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          halves_d = halves_q - HALF_W'(1);
          if (halves_q == HALF_W'(1)) state_d = ST_IDLE;
        end
      end
      ST_SHIFT_LO: begin
        if (tick_c) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (tick_c) begin
`ifdef CFG_SEQ_READBACK_EN
          cap_d[bit_q] = ConfigOut;
`endif
          sreg_d = {1'b0, sreg_q[PAY_W-1:1]};
          if (bit_q == nbits_q) begin
`ifdef CFG_SEQ_READBACK_EN
            state_d = ST_SHIFT_DONE;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            bit_d   = bit_q + BCNT_W'(1);
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_SHIFT_DONE: begin
`ifdef CFG_SEQ_READBACK_EN
        // Only an empty output register is loaded; stall until it is consumed.
        if (!rd_valid_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = cap_q;
        end else if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    cclk_d = (state_d == ST_SHIFT_HI);
    cin_d  = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) && sreg_d[0];
    load_d = (state_d == ST_LOAD);
    rstn_d = (state_d != ST_RESET);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q  <= ST_IDLE;
      halves_q <= '0;
      bit_q    <= '0;
      nbits_q  <= '0;
      sreg_q   <= '0;
      sel_q    <= 1'b0;
      cclk_q   <= 1'b0;
      cin_q    <= 1'b0;
      load_q   <= 1'b0;
      rstn_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      halves_q <= halves_d;
      bit_q    <= bit_d;
      nbits_q  <= nbits_d;
      sreg_q   <= sreg_d;
      sel_q    <= sel_d;
      cclk_q   <= cclk_d;
      cin_q    <= cin_d;
      load_q   <= load_d;
      rstn_q   <= rstn_d;
    end
  end

`ifdef CFG_SEQ_READBACK_EN
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = {(C_DATA_WIDTH - PAY_W)'(0), rd_data_q};
  assign unused_c = ^{cmd_data[15:8], cmd_data[3], restart_c};
`else
  assign rd_valid = 1'b0;
  assign rd_data  = '0;
  assign unused_c = ^{cmd_data[15:8], cmd_data[3], restart_c, ConfigOut, rd_ready};
`endif

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign SuperpixSel = sel_q;
  assign ConfigClk   = cclk_q;
  assign ConfigIn    = cin_q;
  assign ConfigLoad  = load_q;
  assign Reset_not   = rstn_q;

endmodule
